flow_fifo: RTL and testbench
============================

FLOW_FIFO -- requirements
Module: flow_fifo

Interface
REQ-001 SHALL have parameter D_WIDTH, default 6, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, number of storage entries (power of two, >=2).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1, almost_full threshold (1..DEPTH).
REQ-004 SHALL have parameter AE_LEVEL, default 1, almost_empty threshold (0..DEPTH-1).
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port up_data  input  D_WIDTH  upstream payload.
REQ-008 SHALL have port up_valid  input  1  upstream offers up_data.
REQ-009 SHALL have port up_ready  output  1  block accepts up_data this cycle.
REQ-010 SHALL have port down_data  output  D_WIDTH  head-of-queue payload.
REQ-011 SHALL have port down_valid  output  1  down_data is valid.
REQ-012 SHALL have port down_ready  input  1  downstream accepts down_data.
REQ-013 SHALL have port flush  input  1  synchronous discard of all stored entries.
REQ-014 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.
REQ-015 SHALL have port almost_full  output  1  count >= AF_LEVEL.
REQ-016 SHALL have port almost_empty  output  1  count <= AE_LEVEL.

Function
REQ-017 SHALL define push = up_valid & up_ready and pop = down_valid & down_ready, both evaluated at the rising clk edge.
REQ-018 SHALL drive up_ready = (count != DEPTH) & ~flush; up_ready SHALL NOT depend combinationally on down_ready or up_valid.
REQ-019 SHALL operate first-word-fall-through: down_valid = (count != 0), with down_data equal to the oldest stored entry whenever down_valid is high.
REQ-020 SHALL present a word pushed at edge N on down_data/down_valid in the cycle after edge N when the queue was empty (1-cycle latency).
REQ-021 SHALL deliver words in exact push order, with no loss or duplication.
REQ-022 SHALL hold down_data stable while down_valid=1 and down_ready=0.
REQ-023 SHALL update count per edge: push-only +1; pop-only -1; push and pop together unchanged; neither unchanged.
REQ-024 SHALL allow push and pop at the same edge when 0 < count < DEPTH; at count=DEPTH only pop occurs (up_ready=0); at count=0 only push occurs (down_valid=0).
REQ-025 SHALL wrap read and write pointers modulo DEPTH without a gap or a stall at the wrap.
REQ-026 SHALL, when flush=1 at an edge, set count to 0 and pointers equal at that edge, ignoring any simultaneous pop and any up_valid (up_ready is already 0).
REQ-027 SHALL derive almost_full and almost_empty from the registered count only, so both change in the cycle after the causing edge.
REQ-028 SHALL not reset the storage array; contents of unoccupied entries are don't-care and SHALL never appear with down_valid=1.
REQ-029 SHALL reject illegal parameters (DEPTH not a power of two or <2, AF_LEVEL or AE_LEVEL out of range) with an elaboration-time error.

Reset
REQ-030 SHALL, when rst=1 at an edge, set count=0 and both pointers=0, which gives down_valid=0, up_ready=1 (if flush=0), almost_full=0 and almost_empty=1.
REQ-031 SHALL give rst priority over flush, push and pop; a reset in mid-operation discards all entries, and the first push after reset is the first word out.
REQ-032 SHALL drive down_data to a defined value of 0 from the first reset, until the first push.

Verification (D_WIDTH=6, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-033 SHALL cover fill to full: push 1,2,3,4 with down_ready=0 -> count 1..4, almost_full=1 at count 3, up_ready=0 at count 4, and a 5th up_valid is not accepted.
REQ-034 SHALL cover drain in order: from full, down_ready=1 -> down_data 1,2,3,4 on consecutive cycles, then down_valid=0, almost_empty=1 at count<=1.
REQ-035 SHALL cover streaming: continuous up_valid=1/down_ready=1 for 20 words 0..19 -> after a 1-cycle latency, one word out per cycle in order, count stays 1, and pointers wrap 5 times.
REQ-036 SHALL cover simultaneous push and pop at count=2 -> count stays 2, the head advances and the new word is queued last.
REQ-037 SHALL cover flush at count=3 with up_valid=1 and down_ready=1 -> next cycle count=0, down_valid=0, no word consumed and no word accepted.
REQ-038 SHALL cover reset mid-stream at count=2 -> next cycle count=0, down_valid=0, up_ready=1; a following push of 0x2A appears on down_data one cycle later.

Source files
------------

// File: rtl/flow_fifo.sv
// flow_fifo: first-word-fall-through FIFO with valid/ready on both sides,
// synchronous flush, occupancy count and almost_full/almost_empty flags.
module flow_fifo #(
   parameter int D_WIDTH  = 6,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [D_WIDTH-1:0]         up_data,
   input  logic                       up_valid,
   output logic                       up_ready,
   output logic [D_WIDTH-1:0]         down_data,
   output logic                       down_valid,
   input  logic                       down_ready,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       almost_full,
   output logic                       almost_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   if (D_WIDTH < 1) begin : g_bad_width
      $error("flow_fifo: D_WIDTH must be >= 1");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("flow_fifo: DEPTH must be a power of two >= 2");
   end
   if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("flow_fifo: AF_LEVEL must be in 1..DEPTH");
   end
   if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
      $error("flow_fifo: AE_LEVEL must be in 0..DEPTH-1");
   end

   logic [D_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic               push;
   logic               pop;

   // Handshake qualifiers; up_ready only looks at registered state and flush.
   always_comb begin
      up_ready   = (count != CW'(DEPTH)) & ~flush;
      down_valid = (count != '0);
      push       = up_valid & up_ready;
      pop        = down_valid & down_ready;
   end

   // Head of queue; forced to zero while empty so it is defined after reset.
   always_comb begin
      down_data = '0;
      if (down_valid) begin
         down_data = mem[rd_ptr];
      end
   end

   // Flags come from the registered count only.
   always_comb begin
      almost_full  = (count >= CW'(AF_LEVEL));
      almost_empty = (count <= CW'(AE_LEVEL));
   end

   // Storage array is never reset; unoccupied entries are hidden by down_valid.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem[wr_ptr] <= up_data;
      end
   end

   // Pointers and occupancy; reset beats flush, flush beats push/pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_flow_fifo.sv
// tb_flow_fifo: directed stimulus with a queue-based reference model
// compared every cycle, plus literal expectations for the key scenarios.
module tb_flow_fifo;

   localparam int W  = 6;
   localparam int D  = 4;
   localparam int AF = 3;
   localparam int AE = 1;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] up_data = '0;
   logic         up_valid = 1'b0;
   logic         up_ready;
   logic [W-1:0] down_data;
   logic         down_valid;
   logic         down_ready = 1'b0;
   logic         flush = 1'b0;
   logic [2:0]   count;
   logic         almost_full;
   logic         almost_empty;

   int errors = 0;
   int checks = 0;

   logic [W-1:0] q[$];
   bit           m_rst_seen = 1'b0;
   bit           m_pushed = 1'b0;

   flow_fifo #(
      .D_WIDTH (W),
      .DEPTH   (D),
      .AF_LEVEL(AF),
      .AE_LEVEL(AE)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .up_data     (up_data),
      .up_valid    (up_valid),
      .up_ready    (up_ready),
      .down_data   (down_data),
      .down_valid  (down_valid),
      .down_ready  (down_ready),
      .flush       (flush),
      .count       (count),
      .almost_full (almost_full),
      .almost_empty(almost_empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue updated from the interface rules.
   always @(posedge clk) begin
      bit mpush;
      bit mpop;
      mpush = up_valid && (q.size() != D) && !flush;
      mpop  = (q.size() != 0) && down_ready;
      if (rst) begin
         q.delete();
         m_rst_seen = 1'b1;
      end else if (flush) begin
         q.delete();
      end else begin
         if (mpop) void'(q.pop_front());
         if (mpush) begin
            q.push_back(up_data);
            m_pushed = 1'b1;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_rst_seen) begin
         chk("m_up_ready", int'(up_ready), int'((q.size() != D) && !flush));
         chk("m_down_valid", int'(down_valid), int'(q.size() != 0));
         if (q.size() != 0)
            chk("m_down_data", int'(down_data), int'(q[0]));
         else if (!m_pushed)
            chk("m_data_zero", int'(down_data), 0);
         chk("m_count", int'(count), q.size());
         chk("m_almost_full", int'(almost_full), int'(q.size() >= AF));
         chk("m_almost_empty", int'(almost_empty), int'(q.size() <= AE));
      end
   end

   task automatic step(input bit v, input int d, input bit r,
                       input bit f, input bit rs);
      up_valid   = v;
      up_data    = W'(d);
      down_ready = r;
      flush      = f;
      rst        = rs;
      @(posedge clk);
      #1;
   endtask

   initial begin
      @(posedge clk);
      #1;
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      chk("rst_count", int'(count), 0);
      chk("rst_valid", int'(down_valid), 0);
      chk("rst_ready", int'(up_ready), 1);
      chk("rst_af", int'(almost_full), 0);
      chk("rst_ae", int'(almost_empty), 1);
      chk("rst_data", int'(down_data), 0);

      // fill to full
      for (int i = 1; i <= 4; i++) begin
         step(1, i, 0, 0, 0);
         chk("fill_count", int'(count), i);
         chk("fill_af", int'(almost_full), int'(i >= 3));
         chk("fill_ready", int'(up_ready), int'(i != 4));
      end
      step(1, 5, 0, 0, 0);
      chk("full_reject", int'(count), 4);
      chk("full_head", int'(down_data), 1);

      // drain in order
      for (int i = 1; i <= 4; i++) begin
         chk("drain_data", int'(down_data), i);
         step(0, 0, 1, 0, 0);
         chk("drain_count", int'(count), 4 - i);
         chk("drain_ae", int'(almost_empty), int'(4 - i <= 1));
      end
      chk("drain_valid", int'(down_valid), 0);

      // streaming across five pointer wraps
      for (int i = 0; i < 20; i++) begin
         step(1, i, 1, 0, 0);
         chk("stream_count", int'(count), 1);
         chk("stream_data", int'(down_data), i);
      end
      step(0, 0, 1, 0, 0);
      chk("stream_empty", int'(down_valid), 0);

      // simultaneous push and pop at count 2
      step(1, 10, 0, 0, 0);
      step(1, 11, 0, 0, 0);
      step(1, 12, 1, 0, 0);
      chk("pp_count", int'(count), 2);
      chk("pp_head", int'(down_data), 11);
      step(0, 0, 1, 0, 0);
      chk("pp_tail", int'(down_data), 12);
      step(0, 0, 1, 0, 0);
      chk("pp_empty", int'(count), 0);

      // flush at count 3 with traffic on both sides
      step(1, 20, 0, 0, 0);
      step(1, 21, 0, 0, 0);
      step(1, 22, 0, 0, 0);
      up_valid = 1'b1;
      up_data = W'(23);
      down_ready = 1'b1;
      flush = 1'b1;
      #1;
      chk("flush_ready", int'(up_ready), 0);
      step(1, 23, 1, 1, 0);
      chk("flush_count", int'(count), 0);
      chk("flush_valid", int'(down_valid), 0);
      step(1, 24, 0, 0, 0);
      chk("post_flush", int'(down_data), 24);
      step(0, 0, 1, 0, 0);

      // reset mid-stream at count 2
      step(1, 30, 0, 0, 0);
      step(1, 31, 0, 0, 0);
      chk("pre_rst", int'(count), 2);
      step(0, 0, 0, 0, 1);
      chk("mid_rst_count", int'(count), 0);
      chk("mid_rst_valid", int'(down_valid), 0);
      chk("mid_rst_ready", int'(up_ready), 1);
      step(1, 42, 0, 0, 0);
      chk("rst_push_valid", int'(down_valid), 1);
      chk("rst_push_data", int'(down_data), 42);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
